victim_way_picker: RTL and testbench

VICTIM_WAY_PICKER -- requirements
Module: victim_way_picker

---
 rtl/way_sel_pkg.sv | 20 ++
 rtl/lfsr16.sv | 39 +++
 rtl/victim_way_picker.sv | 180 ++++++++++++++++++
 tb/tb_victim_way_picker.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/way_sel_pkg.sv
// Shared constants and types for the victim way picker.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package way_sel_pkg;

  localparam int NUM_WAYS   = 16;
  localparam int WAY_ID_W   = 4;
  localparam int WAY_CODE_W = 5;

  // Feedback taps for x^16 + x^14 + x^13 + x^11 + 1 on a left-shifting
  // register: bits 15, 13, 12 and 10 are XORed into bit 0.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : way_sel_pkg

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that advances on every clock, reset to SEED.
// Latency: new value every cycle; no handshake.
// Backpressure: none, free-running.
//
// Ports:
//   clk       - clock, state updates on posedge
//   reset_n   - asynchronous active-low reset, loads SEED
//   lfsr_out  - current register contents
module lfsr16
  import way_sel_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] lfsr_out
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  // Parity of the tapped bits is the new bit shifted in at the bottom.
  always_comb begin
    fb     = ^(lfsr_q & LFSR_TAPS);
    lfsr_d = {lfsr_q[14:0], fb};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_out = lfsr_q;

endmodule : lfsr16

// File: rtl/victim_way_picker.sv
// Picks a cache victim way: free way first, else pseudo-random unlocked way.
// Latency: 1 cycle when decided at capture, up to 16 cycles when scanning.
// Backpressure: result held in DONE until out_ready; req_ready low outside IDLE.
//
// Ports:
//   clk, reset_n           - clock and asynchronous active-low reset
//   req_valid / req_ready  - request handshake, accepted only in IDLE
//   valid_in, lock_in      - per-way valid and lock bits, sampled at acceptance
//   way1_out, way2_out     - way codes {id, keep}; keep=0 means invalidate
//   out_valid / out_ready  - result handshake
//   free_hit, all_locked   - result qualifiers
module victim_way_picker
  import way_sel_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  valid_in [NUM_WAYS-1:0],
  input  logic                  lock_in  [NUM_WAYS-1:0],
  output logic [WAY_CODE_W-1:0] way1_out,
  output logic [WAY_CODE_W-1:0] way2_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  free_hit,
  output logic                  all_locked
);

  localparam logic [WAY_CODE_W-1:0] CODE_IDLE = '1;

  logic [15:0] lfsr;
  logic        lfsr_unused;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset_n  (reset_n),
    .lfsr_out (lfsr)
  );

  // Only the low nibble picks the start way; the rest just keeps cycling.
  assign lfsr_unused = ^lfsr[15:WAY_ID_W];

  state_e                state_q, state_d;
  logic [WAY_ID_W-1:0]   ptr_q, ptr_d;
  logic [WAY_ID_W-1:0]   start_q, start_d;
  logic [NUM_WAYS-1:0]   lock_q, lock_d;
  logic [WAY_CODE_W-1:0] way1_q, way1_d;
  logic [WAY_CODE_W-1:0] way2_q, way2_d;
  logic                  free_q, free_d;
  logic                  alock_q, alock_d;

  logic [NUM_WAYS-1:0]   valid_vec;
  logic [NUM_WAYS-1:0]   lock_vec;
  logic                  any_free;
  logic [WAY_ID_W-1:0]   free_idx;
  logic [WAY_ID_W-1:0]   lfsr_start;
  logic [WAY_ID_W-1:0]   ptr_next;

  always_comb begin
    for (int i = 0; i < NUM_WAYS; i++) begin
      valid_vec[i] = valid_in[i];
      lock_vec[i]  = lock_in[i];
    end
  end

  // Priority encoder: lowest-numbered invalid way wins. Walking from the top
  // down lets the lowest index overwrite any higher one.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        any_free = 1'b1;
        free_idx = WAY_ID_W'(i);
      end
    end
  end

  assign lfsr_start = lfsr[WAY_ID_W-1:0];
  assign ptr_next   = ptr_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    start_d = start_q;
    lock_d  = lock_q;
    way1_d  = way1_q;
    way2_d  = way2_q;
    free_d  = free_q;
    alock_d = alock_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          start_d = lfsr_start;
          lock_d  = lock_vec;
          free_d  = 1'b0;
          alock_d = 1'b0;
          if (any_free) begin
            // A free way needs no eviction; lock bits do not matter here.
            way1_d  = {free_idx, 1'b1};
            way2_d  = {free_idx, 1'b1};
            free_d  = 1'b1;
            state_d = DONE;
          end else if (!lock_vec[lfsr_start]) begin
            way1_d  = {lfsr_start, 1'b0};
            way2_d  = {lfsr_start, 1'b1};
            state_d = DONE;
          end else begin
            ptr_d   = lfsr_start + 1'b1;
            state_d = SCAN;
          end
        end
      end

      SCAN: begin
        if (!lock_q[ptr_q]) begin
          way1_d  = {start_q, 1'b1};
          way2_d  = {ptr_q, 1'b0};
          state_d = DONE;
        end else if (ptr_next == start_q) begin
          // Every other way probed and locked: nothing can be evicted.
          way1_d  = {start_q, 1'b1};
          way2_d  = {start_q, 1'b1};
          alock_d = 1'b1;
          state_d = DONE;
        end else begin
          ptr_d = ptr_next;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      start_q <= '0;
      lock_q  <= '0;
      way1_q  <= CODE_IDLE;
      way2_q  <= CODE_IDLE;
      free_q  <= 1'b0;
      alock_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      start_q <= start_d;
      lock_q  <= lock_d;
      way1_q  <= way1_d;
      way2_q  <= way2_d;
      free_q  <= free_d;
      alock_q <= alock_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  // Outside DONE the codes read as keep-everything so a consumer that
  // glances at them early can never invalidate a line.
  assign way1_out   = out_valid ? way1_q : CODE_IDLE;
  assign way2_out   = out_valid ? way2_q : CODE_IDLE;
  assign free_hit   = out_valid & free_q;
  assign all_locked = out_valid & alock_q;

endmodule : victim_way_picker

// File: tb/tb_victim_way_picker.sv
// Directed self-checking bench for victim_way_picker.
// Latency: checks 1-cycle capture decisions and multi-cycle scans.
// Backpressure: exercises out_ready hold-off and back-to-back requests.
module tb_victim_way_picker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic       valid_in [15:0];
  logic       lock_in  [15:0];
  logic [4:0] way1_out;
  logic [4:0] way2_out;
  logic       out_valid;
  logic       out_ready;
  logic       free_hit;
  logic       all_locked;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  victim_way_picker #(
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .valid_in   (valid_in),
    .lock_in    (lock_in),
    .way1_out   (way1_out),
    .way2_out   (way2_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .free_hit   (free_hit),
    .all_locked (all_locked)
  );

  // Reference LFSR: x^16+x^14+x^13+x^11+1, shifting left, new bit at [0].
  logic [15:0] model_lfsr;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_lfsr <= 16'hACE1;
    else model_lfsr <= {model_lfsr[14:0],
                        model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [15:0] v, input logic [15:0] l);
    for (int i = 0; i < 16; i++) begin
      valid_in[i] = v[i];
      lock_in[i]  = l[i];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request; after the accepting edge lock_in is replaced by
  // post_lock to show the DUT works from its captured copy.
  task automatic issue(input logic [15:0] post_lock, output logic [3:0] s, output int lat);
    s = model_lfsr[3:0];
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 16; i++) lock_in[i] = post_lock[i];
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("consume_out_valid", 32'(out_valid), 32'd0);
    chk("consume_req_ready", 32'(req_ready), 32'd1);
  endtask

  logic [3:0] s;
  int         lat;
  logic [4:0] h1, h2;
  int         pulses;

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    out_ready = 1'b0;
    set_in(16'hFFFF, 16'hFFFF);
    step();
    step();
    reset_n = 1'b1;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_way1", 32'(way1_out), 32'h1F);
    chk("rst_way2", 32'(way2_out), 32'h1F);
    chk("rst_free_hit", 32'(free_hit), 32'd0);
    chk("rst_all_locked", 32'(all_locked), 32'd0);

    // Free ways 5 and 2, everything locked: lowest free way wins
    set_in(16'hFFDB, 16'hFFFF);
    issue(16'hFFFF, s, lat);
    chk("free_lat", 32'(lat), 32'd1);
    chk("free_way1", 32'(way1_out), 32'h05);
    chk("free_way2", 32'(way2_out), 32'h05);
    chk("free_hit", 32'(free_hit), 32'd1);
    chk("free_all_locked", 32'(all_locked), 32'd0);
    consume();

    // All valid, all unlocked: start way evicted immediately
    set_in(16'hFFFF, 16'h0000);
    issue(16'h0000, s, lat);
    chk("unl_lat", 32'(lat), 32'd1);
    chk("unl_way1", 32'(way1_out), 32'({s, 1'b0}));
    chk("unl_way2", 32'(way2_out), 32'({s, 1'b1}));
    chk("unl_free_hit", 32'(free_hit), 32'd0);
    consume();

    // Only way 9 unlocked, start != 9: scan to way 9
    set_in(16'hFFFF, 16'hFDFF);
    while (model_lfsr[3:0] == 4'd9) step();
    issue(16'h0000, s, lat);
    chk("scan9_lat", 32'(lat), 32'(1 + ((9 - int'(s)) & 15)));
    chk("scan9_way1", 32'(way1_out), 32'({s, 1'b1}));
    chk("scan9_way2", 32'(way2_out), 32'h12);
    chk("scan9_all_locked", 32'(all_locked), 32'd0);
    consume();

    // All locked: full scan, then hold the result under backpressure
    set_in(16'hFFFF, 16'hFFFF);
    issue(16'hFFFF, s, lat);
    chk("lock_lat", 32'(lat), 32'd16);
    chk("lock_all_locked", 32'(all_locked), 32'd1);
    chk("lock_way1", 32'(way1_out), 32'({s, 1'b1}));
    chk("lock_way2", 32'(way2_out), 32'({s, 1'b1}));
    h1 = way1_out;
    h2 = way2_out;
    set_in(16'h0000, 16'h0000);
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_way1", 32'(way1_out), 32'(h1));
      chk("hold_way2", 32'(way2_out), 32'(h2));
      chk("hold_free_hit", 32'(free_hit), 32'd0);
      chk("hold_all_locked", 32'(all_locked), 32'd1);
    end
    req_valid = 1'b0;
    consume();

    // Reset asserted in the middle of a scan
    set_in(16'hFFFF, 16'hFFFF);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    chk("midscan_out_valid", 32'(out_valid), 32'd0);
    chk("midscan_req_ready", 32'(req_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_way1", 32'(way1_out), 32'h1F);
    chk("midrst_way2", 32'(way2_out), 32'h1F);
    chk("midrst_all_locked", 32'(all_locked), 32'd0);
    step();
    reset_n = 1'b1;
    chk("postrst_req_ready", 32'(req_ready), 32'd1);
    set_in(16'hEFFF, 16'hFFFF);
    issue(16'hFFFF, s, lat);
    chk("postrst_lat", 32'(lat), 32'd1);
    chk("postrst_way1", 32'(way1_out), 32'h19);
    chk("postrst_free_hit", 32'(free_hit), 32'd1);
    consume();
    set_in(16'hFFFF, 16'h0000);
    issue(16'h0000, s, lat);
    chk("postrst_unl_way1", 32'(way1_out), 32'({s, 1'b0}));
    chk("postrst_unl_way2", 32'(way2_out), 32'({s, 1'b1}));
    consume();

    // Back-to-back requests with out_ready tied high
    set_in(16'hFFFF, 16'h0000);
    out_ready = 1'b1;
    req_valid = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      chk("b2b_req_ready", 32'(req_ready), 32'd1);
      chk("b2b_idle_out_valid", 32'(out_valid), 32'd0);
      s = model_lfsr[3:0];
      step();
      if (out_valid === 1'b1) pulses++;
      chk("b2b_way1", 32'(way1_out), 32'({s, 1'b0}));
      chk("b2b_way2", 32'(way2_out), 32'({s, 1'b1}));
      step();
    end
    req_valid = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd10);
    chk("b2b_final_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_victim_way_picker
